// File: rtl/log_perf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : log_perf_ctrl
// Description : Simulation-top generator of the global perf/log controls.
//               Owns the free-running cycle timer, the log window, periodic
//               perf-dump scheduling, and arbitration between periodic dumps
//               and an external dump requester.
// Ports       : clock, reset         - clock, synchronous active-high reset
//               cfg_valid/cfg_ready  - config write handshake
//               cfg_log_begin/end    - log window [begin, end)
//               cfg_interval         - periodic dump interval (0 = off)
//               ext_dump_req/ack     - external dump request / service pulse
//               timer                - global cycle count
//               log_enable           - log window active
//               dump, clean          - one-cycle perf dump / clear strobes
//               busy                 - dump/clean sequence in progress
// Option      : define LOG_PERF_CTRL_FINAL_DUMP_EN to add input sim_finish
//               and an absorbing FINAL state reached after one last dump.
// Revision    : 1.0 - initial release
// ============================================================================
module log_perf_ctrl #(
  parameter int TIMER_W    = 64,
  parameter int INTERVAL_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [TIMER_W-1:0]    cfg_log_begin,
  input  logic [TIMER_W-1:0]    cfg_log_end,
  input  logic [INTERVAL_W-1:0] cfg_interval,
  input  logic                  ext_dump_req,
  output logic                  ext_dump_ack,
`ifdef LOG_PERF_CTRL_FINAL_DUMP_EN
  input  logic                  sim_finish,
`endif
  output logic [TIMER_W-1:0]    timer,
  output logic                  log_enable,
  output logic                  dump,
  output logic                  clean,
  output logic                  busy
);

  localparam logic [TIMER_W-1:0]    c_TIMER_ONE    = {{(TIMER_W-1){1'b0}}, 1'b1};
  localparam logic [INTERVAL_W-1:0] c_INTERVAL_ONE = {{(INTERVAL_W-1){1'b0}}, 1'b1};

`ifdef LOG_PERF_CTRL_FINAL_DUMP_EN
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DUMP  = 2'd1,
    ST_CLEAN = 2'd2,
    ST_FINAL = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DUMP  = 2'd1,
    ST_CLEAN = 2'd2
  } state_t;
`endif

  state_t                r_state;
  logic [TIMER_W-1:0]    r_timer;
  logic [TIMER_W-1:0]    r_begin;
  logic [TIMER_W-1:0]    r_end;
  logic [INTERVAL_W-1:0] r_interval;
  logic [INTERVAL_W-1:0] r_counter;
  logic                  r_log_enable;
  logic                  r_dump;
  logic                  r_clean;
  logic                  r_busy;
  logic                  r_ext_ack;
  logic                  r_ext_flag;
`ifdef LOG_PERF_CTRL_FINAL_DUMP_EN
  logic                  r_final_seq;    // current DUMP leads to FINAL
  logic                  r_finish_pend;  // sim_finish seen during a sequence
  logic                  w_finish_req;
`endif

  logic                  w_cfg_fire;
  logic [TIMER_W-1:0]    w_timer_next;
  logic [TIMER_W-1:0]    w_begin_eff;
  logic [TIMER_W-1:0]    w_end_eff;
  logic                  w_log_next;
  logic                  w_period_hit;
  logic                  w_trigger;

  assign cfg_ready    = (r_state == ST_RUN);
  assign w_cfg_fire   = cfg_valid && cfg_ready;
  assign w_timer_next = r_timer + c_TIMER_ONE;

  // log_enable is registered, so it is computed one edge early from the
  // timer and config values that will be in effect in the following cycle.
  assign w_begin_eff  = w_cfg_fire ? cfg_log_begin : r_begin;
  assign w_end_eff    = w_cfg_fire ? cfg_log_end   : r_end;
  assign w_log_next   = (w_begin_eff <= w_timer_next) && (w_timer_next < w_end_eff);

  assign w_period_hit = (r_interval != '0) && (r_counter == (r_interval - c_INTERVAL_ONE));
  assign w_trigger    = ext_dump_req || w_period_hit;

`ifdef LOG_PERF_CTRL_FINAL_DUMP_EN
  assign w_finish_req = sim_finish || r_finish_pend;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_timer       <= '0;
      r_begin       <= '0;
      r_end         <= '0;
      r_interval    <= '0;
      r_counter     <= '0;
      r_log_enable  <= 1'b0;
      r_dump        <= 1'b0;
      r_clean       <= 1'b0;
      r_busy        <= 1'b0;
      r_ext_ack     <= 1'b0;
      r_ext_flag    <= 1'b0;
`ifdef LOG_PERF_CTRL_FINAL_DUMP_EN
      r_final_seq   <= 1'b0;
      r_finish_pend <= 1'b0;
`endif
    end else begin
      // Timer and log window keep running in every state.
      r_timer      <= w_timer_next;
      r_log_enable <= w_log_next;

      if (w_cfg_fire) begin
        r_begin    <= cfg_log_begin;
        r_end      <= cfg_log_end;
        r_interval <= cfg_interval;
      end

      case (r_state)
        ST_RUN: begin
          if (w_cfg_fire) begin
            r_counter <= '0;
          end else if (r_interval != '0) begin
            r_counter <= r_counter + c_INTERVAL_ONE;
          end
`ifdef LOG_PERF_CTRL_FINAL_DUMP_EN
          if (w_finish_req) begin
            r_state       <= ST_DUMP;
            r_dump        <= 1'b1;
            r_busy        <= 1'b1;
            r_ext_flag    <= 1'b0;
            r_final_seq   <= 1'b1;
            r_finish_pend <= 1'b0;
          end else
`endif
          if (w_trigger) begin
            r_state    <= ST_DUMP;
            r_dump     <= 1'b1;
            r_busy     <= 1'b1;
            r_ext_flag <= ext_dump_req;
          end
        end

        ST_DUMP: begin
          r_dump <= 1'b0;
`ifdef LOG_PERF_CTRL_FINAL_DUMP_EN
          if (r_final_seq) begin
            r_state <= ST_FINAL;
            r_busy  <= 1'b0;
          end else begin
            if (sim_finish) begin
              r_finish_pend <= 1'b1;
            end
            r_state   <= ST_CLEAN;
            r_clean   <= 1'b1;
            r_ext_ack <= r_ext_flag;
          end
`else
          r_state   <= ST_CLEAN;
          r_clean   <= 1'b1;
          r_ext_ack <= r_ext_flag;
`endif
        end

        ST_CLEAN: begin
`ifdef LOG_PERF_CTRL_FINAL_DUMP_EN
          if (sim_finish) begin
            r_finish_pend <= 1'b1;
          end
`endif
          r_state    <= ST_RUN;
          r_clean    <= 1'b0;
          r_busy     <= 1'b0;
          r_ext_ack  <= 1'b0;
          r_ext_flag <= 1'b0;
          r_counter  <= '0;
        end

`ifdef LOG_PERF_CTRL_FINAL_DUMP_EN
        // Absorbing until reset; only timer and log_enable keep updating.
        ST_FINAL: begin
          r_state <= ST_FINAL;
        end
`endif

        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  assign timer        = r_timer;
  assign log_enable   = r_log_enable;
  assign dump         = r_dump;
  assign clean        = r_clean;
  assign busy         = r_busy;
  assign ext_dump_ack = r_ext_ack;

endmodule
`default_nettype wire
